// File: rtl/bus_arbiter_pkg.sv
// ============================================================================
// Module : bus_arbiter_pkg
// Brief  : Shared state encodings, bus width default and clog2 helper for the
//          round-robin bus arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bus_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    localparam int DATA_BUS_WIDTH_DEF = 32;

    // Never returns less than 1, so a 1-bit index still exists for tiny configs.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin search: first set request after i_last.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick
    import bus_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_pick
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] w_idx;

    // Wrap is an explicit compare so non-power-of-two counts stay in range.
    always_comb begin
        o_found = 1'b0;
        o_pick  = '0;
        w_idx   = i_last;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = (w_idx == c_LAST_IDX) ? '0 : w_idx + 1'b1;
            if (!o_found && i_req[w_idx]) begin
                o_found = 1'b1;
                o_pick  = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module : bus_arbiter
// Brief  : Round-robin bus arbiter with one-cycle high-Z turnaround and a
//          hold limit that forces release when another source is waiting.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int MAX_HOLD = 8,
    localparam int OW       = clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [OW-1:0]      owner,
    output logic               bus_idle,
    output logic               timeout
);

    localparam int               HW         = clog2(MAX_HOLD);
    localparam logic [HW-1:0]    c_HOLD_MAX = HW'(MAX_HOLD - 1);
    localparam logic [OW-1:0]    c_LAST_RST = OW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_ONE    = NUM_REQ'(1);

    logic [1:0]         r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [OW-1:0]      r_owner;
    logic [OW-1:0]      r_last;
    logic [HW-1:0]      r_hold;
    logic               r_bus_idle;
    logic               r_timeout;

    logic [1:0]         w_state_nx;
    logic [NUM_REQ-1:0] w_gnt_nx;
    logic [OW-1:0]      w_owner_nx;
    logic [OW-1:0]      w_last_nx;
    logic [HW-1:0]      w_hold_nx;
    logic               w_timeout_nx;
    logic               w_found;
    logic [OW-1:0]      w_pick;
    logic               w_others_wait;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req   (req),
        .i_last  (r_last),
        .o_found (w_found),
        .o_pick  (w_pick)
    );

    // In GRANT r_gnt is exactly the owner's bit, so masking it leaves the waiters.
    assign w_others_wait = |(req & ~r_gnt);

    always_comb begin
        w_state_nx   = r_state;
        w_gnt_nx     = r_gnt;
        w_owner_nx   = r_owner;
        w_last_nx    = r_last;
        w_hold_nx    = r_hold;
        w_timeout_nx = 1'b0;
        case (r_state)
            ST_IDLE, ST_TURN: begin
                if (w_found) begin
                    w_state_nx = ST_GRANT;
                    w_gnt_nx   = c_ONE << w_pick;
                    w_owner_nx = w_pick;
                    w_hold_nx  = '0;
                end else begin
                    w_state_nx = ST_IDLE;
                    w_gnt_nx   = '0;
                end
            end
            ST_GRANT: begin
                if (!req[r_owner]) begin
                    w_state_nx = ST_TURN;
                    w_gnt_nx   = '0;
                    w_last_nx  = r_owner;
                end else if ((r_hold == c_HOLD_MAX) && w_others_wait) begin
                    w_state_nx   = ST_TURN;
                    w_gnt_nx     = '0;
                    w_last_nx    = r_owner;
                    w_timeout_nx = 1'b1;
                end else if (r_hold != c_HOLD_MAX) begin
                    w_hold_nx = r_hold + 1'b1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_gnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_owner    <= '0;
            r_last     <= c_LAST_RST;
            r_hold     <= '0;
            r_bus_idle <= 1'b1;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_gnt      <= w_gnt_nx;
            r_owner    <= w_owner_nx;
            r_last     <= w_last_nx;
            r_hold     <= w_hold_nx;
            r_bus_idle <= (w_gnt_nx == '0);
            r_timeout  <= w_timeout_nx;
        end
    end

    assign gnt      = r_gnt;
    assign owner    = r_owner;
    assign bus_idle = r_bus_idle;
    assign timeout  = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module : tb_bus_arbiter
// Brief  : Directed scenarios plus randomized requests against a reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    localparam int NR   = 4;
    localparam int MAXH = 8;
    localparam int DW   = bus_arbiter_pkg::DATA_BUS_WIDTH_DEF;

    logic          clk;
    logic          reset;
    logic [NR-1:0] req;
    logic [NR-1:0] gnt;
    logic [1:0]    owner;
    logic          bus_idle;
    logic          timeout;

    int n_tests;
    int n_fail;

    // Reference model: who owns the bus, who had it last, how long held.
    int            m_owner;
    int            m_last;
    int            m_hold;
    logic [NR-1:0] exp_gnt;
    int            exp_owner;
    logic          exp_to;

    // Emulated shared bus: each source drives only while its grant is high.
    logic [DW-1:0] src_data [NR];
    logic [DW-1:0] bus;
    int            drivers;

    bus_arbiter #(
        .NUM_REQ  (NR),
        .MAX_HOLD (MAXH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .gnt      (gnt),
        .owner    (owner),
        .bus_idle (bus_idle),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus     = '0;
        drivers = 0;
        for (int i = 0; i < NR; i++) begin
            if (gnt[i]) begin
                bus     = bus | src_data[i];
                drivers = drivers + 1;
            end
        end
    end

    task automatic model_edge();
        logic [NR-1:0] others;
        exp_to = 1'b0;
        if (reset) begin
            m_owner   = -1;
            m_last    = NR - 1;
            m_hold    = 0;
            exp_owner = 0;
        end else if (m_owner >= 0) begin
            others = req & ~(NR'(1) << m_owner);
            if (!req[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (m_hold >= MAXH - 1 && others != 0) begin
                m_last  = m_owner;
                m_owner = -1;
                exp_to  = 1'b1;
            end else if (m_hold < MAXH - 1) begin
                m_hold = m_hold + 1;
            end
        end else begin
            for (int k = 1; k <= NR; k++) begin
                if (m_owner < 0 && req[(m_last + k) % NR]) begin
                    m_owner = (m_last + k) % NR;
                end
            end
            if (m_owner >= 0) begin
                m_hold    = 0;
                exp_owner = m_owner;
            end
        end
        exp_gnt = (m_owner >= 0) ? (NR'(1) << m_owner) : '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_tests++;
            if (gnt !== 4'b0000 || bus_idle !== 1'b1 || owner !== 2'd0 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL reset c%0d: gnt=%b idle=%b owner=%0d to=%b, want 0000/1/0/0",
                         c, gnt, bus_idle, owner, timeout);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        tick();
        n_tests++;
        if (gnt !== 4'b0100 || owner !== 2'd2 || bus_idle !== 1'b0) begin
            n_fail++;
            $display("FAIL single_grant: gnt=%b owner=%0d idle=%b, want 0100/2/0", gnt, owner, bus_idle);
        end
        req = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_tests++;
            if (gnt !== 4'b0000 || bus_idle !== 1'b1) begin
                n_fail++;
                $display("FAIL single_release c%0d: gnt=%b idle=%b, want 0000/1", c, gnt, bus_idle);
            end
        end
    endtask

    task automatic test_rotation();
        int exp;
        do_reset();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp = k % NR;
            n_tests++;
            if (gnt !== (NR'(1) << exp) || owner !== 2'(exp)) begin
                n_fail++;
                $display("FAIL rotation k%0d: gnt=%b owner=%0d, want owner %0d", k, gnt, owner, exp);
            end
            tick();
            tick();
            req[exp] = 1'b0;
            tick();
            n_tests++;
            if (gnt !== 4'b0000 || bus_idle !== 1'b1) begin
                n_fail++;
                $display("FAIL rotation_gap k%0d: gnt=%b idle=%b, want 0000/1", k, gnt, bus_idle);
            end
            req[exp] = 1'b1;
            tick();
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0011;
        tick();
        for (int c = 0; c < MAXH; c++) begin
            n_tests++;
            if (gnt !== 4'b0001 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_hold c%0d: gnt=%b to=%b, want 0001/0", c, gnt, timeout);
            end
            tick();
        end
        n_tests++;
        if (gnt !== 4'b0000 || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_pulse: gnt=%b to=%b, want 0000/1", gnt, timeout);
        end
        tick();
        n_tests++;
        if (gnt !== 4'b0010 || owner !== 2'd1 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_next: gnt=%b owner=%0d to=%b, want 0010/1/0", gnt, owner, timeout);
        end
    endtask

    task automatic test_lone_owner();
        int bad;
        do_reset();
        req = 4'b1000;
        tick();
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (gnt !== 4'b1000 || timeout !== 1'b0) begin
                bad++;
            end
            tick();
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL lone_owner: %0d of 20 cycles wrong, want gnt=1000 to=0 throughout", bad);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b0011;
        tick();
        n_tests++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL midreset_pre: gnt=%b, want 0010", gnt);
        end
        reset = 1'b1;
        tick();
        n_tests++;
        if (gnt !== 4'b0000 || bus_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_drop: gnt=%b idle=%b, want 0000/1", gnt, bus_idle);
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if (gnt !== 4'b0001 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL midreset_regrant: gnt=%b owner=%0d, want 0001/0", gnt, owner);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < NR; b++) begin
                if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
            end
            reset = ($urandom_range(0, 149) == 0);
            tick();
            n_tests++;
            if ($isunknown({gnt, owner, bus_idle, timeout}) || gnt !== exp_gnt
                || bus_idle !== (exp_gnt == '0) || timeout !== exp_to
                || (exp_gnt != '0 && owner !== 2'(exp_owner))) begin
                n_fail++;
                $display("FAIL random c%0d: gnt=%b owner=%0d idle=%b to=%b, want gnt=%b owner=%0d to=%b",
                         c, gnt, owner, bus_idle, timeout, exp_gnt, exp_owner, exp_to);
            end
            n_tests++;
            if (drivers > 1 || $isunknown(bus)
                || (drivers == 1 && bus !== src_data[owner]) || (drivers == 0 && bus !== '0)) begin
                n_fail++;
                $display("FAIL bus c%0d: drivers=%0d bus=%h, want at most one clean driver", c, drivers, bus);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        m_owner   = -1;
        m_last    = NR - 1;
        m_hold    = 0;
        exp_gnt   = '0;
        exp_owner = 0;
        exp_to    = 1'b0;
        reset     = 1'b1;
        req       = '0;
        for (int i = 0; i < NR; i++) begin
            src_data[i] = DW'(32'hA5A5_0000 + i * 32'h0101_1111);
        end
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_lone_owner();
        test_reset_mid_grant();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
